tick_gen: RTL and testbench

- Parametrised, runtime-programmable tick generator; successor to the fixed 1 s cycle counter in the alarm-clock time base.
- Divides clk by a programmable period P and emits a one-cycle `tick` each period, plus a mid-period `half_tick` for 2 Hz display blink.
- Supports periodic and one-shot modes, pause, synchronous clear, and a wrapping tick counter.
- Feeds the seconds/minutes chain and alarm timeout logic.

---
 rtl/tick_gen_if.sv | 29 ++
 rtl/tick_gen.sv | 105 ++++++++++
 tb/tb_tick_gen.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/tick_gen_if.sv
// Control and status bundle for tick_gen: control inputs come from the time-base
// controller, tick/status outputs feed the seconds chain and alarm timeout logic.
interface tick_gen_if #(
    parameter int unsigned CNT_W  = 26,
    parameter int unsigned TCNT_W = 8
);
    logic              en;
    logic              clr;
    logic              mode;
    logic              start;
    logic              period_load;
    logic [CNT_W-1:0]  period_in;
    logic              tick;
    logic              half_tick;
    logic              busy;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  period;
    logic [TCNT_W-1:0] tick_count;

    modport master (
        output en, clr, mode, start, period_load, period_in,
        input  tick, half_tick, busy, count, period, tick_count
    );

    modport slave (
        input  en, clr, mode, start, period_load, period_in,
        output tick, half_tick, busy, count, period, tick_count
    );
endinterface

// File: rtl/tick_gen.sv
// Runtime-programmable clock divider: one-cycle tick per period, a mid-period
// half_tick, periodic or one-shot operation, and a wrapping tick counter.
module tick_gen #(
    parameter int unsigned CNT_W          = 26,
    parameter int unsigned DEFAULT_PERIOD = 50000000,
    parameter int unsigned TCNT_W         = 8
) (
    input  logic        clk,
    input  logic        resetn_sync,
    tick_gen_if.slave   bus
);
    localparam logic [CNT_W-1:0] RESET_PERIOD = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] MIN_PERIOD   = CNT_W'(2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   pending_q, pending_d;
    logic               pending_valid_q, pending_valid_d;
    logic [TCNT_W-1:0]  tick_count_q, tick_count_d;

    logic               running;
    logic               at_last;
    logic               at_half;
    logic               do_apply;
    logic [CNT_W-1:0]   load_val;

    assign running  = (state_q == RUN);
    assign at_last  = (count_q == period_q - CNT_W'(1));
    assign at_half  = (count_q == (period_q >> 1) - CNT_W'(1));
    assign load_val = (bus.period_in < MIN_PERIOD) ? MIN_PERIOD : bus.period_in;

    // A clear overrides the tick even when the count sits on the last cycle.
    assign bus.tick       = running & bus.en & ~bus.clr & at_last;
    assign bus.half_tick  = running & bus.en & at_half;
    assign bus.busy       = running;
    assign bus.count      = count_q;
    assign bus.period     = period_q;
    assign bus.tick_count = tick_count_q;

    always_ff @(posedge clk) begin
        if (!resetn_sync) begin
            state_q         <= IDLE;
            count_q         <= '0;
            period_q        <= RESET_PERIOD;
            pending_q       <= RESET_PERIOD;
            pending_valid_q <= 1'b0;
            tick_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            period_q        <= period_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            tick_count_q    <= tick_count_d;
        end
    end

    // Next-state and datapath; a same-cycle load is visible to the apply step below.
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        period_d        = period_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        tick_count_d    = tick_count_q;
        do_apply        = 1'b0;

        if (bus.period_load) begin
            pending_d       = load_val;
            pending_valid_d = 1'b1;
        end

        if (bus.clr) begin
            count_d      = '0;
            tick_count_d = '0;
            do_apply     = 1'b1;
            state_d      = (!bus.mode && bus.en) ? RUN : IDLE;
        end else if (state_q == IDLE) begin
            count_d  = '0;
            do_apply = 1'b1;
            if (bus.en && (!bus.mode || bus.start)) begin
                state_d = RUN;
            end
        end else if (bus.en) begin
            if (at_last) begin
                count_d      = '0;
                tick_count_d = tick_count_q + TCNT_W'(1);
                do_apply     = 1'b1;
                if (bus.mode) begin
                    state_d = IDLE;
                end
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end

        if (do_apply && pending_valid_d) begin
            period_d        = pending_d;
            pending_valid_d = 1'b0;
        end
    end
endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: directed literal checks plus randomized stimulus compared
// every cycle against an arithmetic model of the tick generator.
module tb_tick_gen;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned TCNT_W = 3;
    localparam int unsigned DEF_P  = 4;

    logic clk = 1'b0;
    logic resetn_sync = 1'b0;
    always #5 clk = ~clk;

    tick_gen_if #(.CNT_W(CNT_W), .TCNT_W(TCNT_W)) bus ();

    tick_gen #(.CNT_W(CNT_W), .DEFAULT_PERIOD(DEF_P), .TCNT_W(TCNT_W)) dut (
        .clk         (clk),
        .resetn_sync (resetn_sync),
        .bus         (bus)
    );

    int errors = 0;
    int checks = 0;
    bit check_on = 1'b0;

    // Model: running flag, cycles elapsed in the interval, period, pending load, ticks.
    int m_run  = 0;
    int m_cnt  = 0;
    int m_per  = DEF_P;
    int m_pend = 0;
    int m_pv   = 0;
    int m_tc   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model_step
        int  req;
        bit  wrap;
        bit  settle;
        req = (int'(bus.period_in) < 2) ? 2 : int'(bus.period_in);
        if (!resetn_sync) begin
            m_run = 0; m_cnt = 0; m_tc = 0; m_per = DEF_P; m_pv = 0;
        end else begin
            wrap   = (m_run != 0) && bus.en && !bus.clr && (m_cnt == m_per - 1);
            settle = bus.clr || (m_run == 0) || wrap;
            if (bus.period_load) begin
                m_pend = req;
                m_pv   = 1;
            end
            if (settle && m_pv != 0) begin
                m_per = m_pend;
                m_pv  = 0;
            end
            if (bus.clr) begin
                m_cnt = 0; m_tc = 0;
                m_run = (!bus.mode && bus.en) ? 1 : 0;
            end else if (m_run == 0) begin
                m_cnt = 0;
                m_run = (bus.en && (!bus.mode || bus.start)) ? 1 : 0;
            end else if (wrap) begin
                m_cnt = 0;
                m_tc  = (m_tc + 1) % (1 << TCNT_W);
                m_run = bus.mode ? 0 : 1;
            end else if (bus.en) begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (check_on) begin
            chk("tick", int'(bus.tick),
                int'((m_run != 0) && bus.en && !bus.clr && (m_cnt == m_per - 1)));
            chk("half_tick", int'(bus.half_tick),
                int'((m_run != 0) && bus.en && (m_cnt == m_per / 2 - 1)));
            chk("busy", int'(bus.busy), m_run);
            chk("count", int'(bus.count), m_cnt);
            chk("period", int'(bus.period), m_per);
            chk("tick_count", int'(bus.tick_count), m_tc);
            chk("count_below_period", int'(bus.count < bus.period), 1);
        end
    end

    task automatic tick_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int cnt_exp[9]  = '{0, 0, 1, 2, 3, 0, 1, 2, 3};
    int tick_exp[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    int half_exp[9] = '{0, 0, 1, 0, 0, 0, 1, 0, 0};
    int busy_n;
    int tick_n;

    initial begin
        bus.en = 1'b1; bus.clr = 1'b0; bus.mode = 1'b0; bus.start = 1'b0;
        bus.period_load = 1'b0; bus.period_in = '0;
        @(posedge clk);
        #1;
        check_on = 1'b1;
        tick_clk(2);

        // Periodic run from reset with the default period of 4.
        resetn_sync = 1'b1;
        for (int k = 0; k <= 33; k++) begin
            @(negedge clk);
            if (k < 9) begin
                chk("lit_count", int'(bus.count), cnt_exp[k]);
                chk("lit_tick", int'(bus.tick), tick_exp[k]);
                chk("lit_half", int'(bus.half_tick), half_exp[k]);
            end
            if (k == 0) chk("lit_idle_busy", int'(bus.busy), 0);
            if (k == 29) chk("lit_tcnt_7", int'(bus.tick_count), 7);
            if (k == 32) chk("lit_8th_tick", int'(bus.tick), 1);
            if (k == 33) chk("lit_tcnt_wrap", int'(bus.tick_count), 0);
        end

        // Period 1 clamps to 2: tick and half_tick alternate.
        tick_clk(1);
        bus.period_in = CNT_W'(1);
        bus.period_load = 1'b1;
        tick_clk(1);
        bus.period_load = 1'b0;
        tick_clk(6);
        @(negedge clk);
        chk("lit_clamp_period", int'(bus.period), 2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lit_alternate", int'(bus.tick ^ bus.half_tick), 1);
        end

        // Reset mid-run restores defaults on the next edge.
        tick_clk(1);
        resetn_sync = 1'b0;
        tick_clk(1);
        @(negedge clk);
        chk("lit_rst_period", int'(bus.period), 4);
        chk("lit_rst_count", int'(bus.count), 0);
        chk("lit_rst_busy", int'(bus.busy), 0);
        chk("lit_rst_tcnt", int'(bus.tick_count), 0);

        // Clear at count 3 with a pending period of 6.
        @(posedge clk);
        #1;
        resetn_sync = 1'b1;
        tick_clk(1);
        bus.period_in = CNT_W'(6);
        bus.period_load = 1'b1;
        tick_clk(1);
        bus.period_load = 1'b0;
        tick_clk(2);
        bus.clr = 1'b1;
        @(negedge clk);
        chk("lit_clr_at_last", int'(bus.count), 3);
        chk("lit_clr_no_tick", int'(bus.tick), 0);
        @(posedge clk);
        #1;
        bus.clr = 1'b0;
        @(negedge clk);
        chk("lit_clr_count", int'(bus.count), 0);
        chk("lit_clr_period", int'(bus.period), 6);
        chk("lit_clr_busy", int'(bus.busy), 1);

        // One-shot: single 4-cycle run per start, start while busy ignored.
        tick_clk(1);
        resetn_sync = 1'b0;
        tick_clk(2);
        resetn_sync = 1'b1;
        bus.mode = 1'b1;
        tick_clk(3);
        @(negedge clk);
        chk("lit_oneshot_idle", int'(bus.busy), 0);
        for (int r = 0; r < 2; r++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b1;
            tick_clk(1);
            bus.start = 1'b0;
            busy_n = 0;
            tick_n = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                busy_n += int'(bus.busy);
                tick_n += int'(bus.tick);
                if (i == 1) bus.start = 1'b1;
                if (i == 2) bus.start = 1'b0;
            end
            chk("lit_oneshot_busy_cycles", busy_n, 4);
            chk("lit_oneshot_ticks", tick_n, 1);
            chk("lit_oneshot_end_count", int'(bus.count), 0);
        end

        // Randomized operation against the model.
        repeat (4000) begin
            @(posedge clk);
            #1;
            resetn_sync     = ($urandom_range(0, 199) != 0);
            bus.en          = ($urandom_range(0, 9) != 0);
            bus.clr         = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) bus.mode = ~bus.mode;
            bus.start       = ($urandom_range(0, 7) == 0);
            bus.period_load = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0)
                bus.period_in = CNT_W'($urandom_range(0, 255));
            else
                bus.period_in = CNT_W'($urandom_range(0, 12));
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
